// File: rtl/ddr_pix_wr_pkg.sv
// ddr_pix_wr_pkg: shared widths, write-FSM state encoding and colour-bar
// constants for the camera-to-DDR pixel writer.
package ddr_pix_wr_pkg;

    localparam int PIX_W        = 24;
    localparam int PIX_PER_WORD = 10;
    localparam int WORD_W       = 240;
    localparam int DATA_W       = 256;
    localparam int ADDR_W       = 28;
    localparam int ADDR_STEP    = 32;
    localparam int CNT_W        = 4;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIX_PER_WORD - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_REQ  = 3'b010,
        ST_DATA = 3'b100
    } wr_state_t;

    localparam int BAR_PIX = 160;

    localparam logic [PIX_W-1:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [PIX_W-1:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [PIX_W-1:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [PIX_W-1:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [PIX_W-1:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [PIX_W-1:0] BAR_RED     = 24'hFF0000;
    localparam logic [PIX_W-1:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [PIX_W-1:0] BAR_BLACK   = 24'h000000;

    function automatic logic [PIX_W-1:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/ddr_pix_wr_if.sv
// ddr_pix_wr_if: pixel stream (vs_in/pix_valid/pix_data/pix_ready) and DDR
// write channel (wr_req/ddr_wr_adr/awlen/ddr_wdata/wdata_ready/ddr_wbusy)
// plus the frame_done pulse.
// slave  : the pixel writer.
// master : the pixel source / DDR controller side.
interface ddr_pix_wr_if;
    import ddr_pix_wr_pkg::*;

    logic              vs_in;
    logic              pix_valid;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_ready;
    logic              wr_req;
    logic [ADDR_W-1:0] ddr_wr_adr;
    logic [3:0]        awlen;
    logic [DATA_W-1:0] ddr_wdata;
    logic              wdata_ready;
    logic              ddr_wbusy;
    logic              frame_done;

    modport slave (
        input  vs_in, pix_valid, pix_data, wdata_ready, ddr_wbusy,
        output pix_ready, wr_req, ddr_wr_adr, awlen, ddr_wdata, frame_done
    );

    modport master (
        output vs_in, pix_valid, pix_data, wdata_ready, ddr_wbusy,
        input  pix_ready, wr_req, ddr_wr_adr, awlen, ddr_wdata, frame_done
    );

endinterface

// File: rtl/ddr_pix_wr_packer.sv
// ddr_pix_wr_packer: packs 10 accepted pixels into one 240-bit word,
// pixel 0 in the MSBs.
// Ports: clk, rstn, i_clr (frame start, drops partial word), i_push (pixel
// accepted), i_pix, o_word_vld (word complete this cycle), o_word.
module ddr_pix_wr_packer
    import ddr_pix_wr_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_clr,
    input  logic              i_push,
    input  logic [PIX_W-1:0]  i_pix,
    output logic              o_word_vld,
    output logic [WORD_W-1:0] o_word
);

    logic [CNT_W-1:0]        r_cnt;
    logic [WORD_W-PIX_W-1:0] r_sh;

    // Stale bits need no clearing: a word is only taken after nine shifts
    // since the last clear, which flushes them out of the top.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
            r_sh  <= '0;
        end else if (i_push) begin
            r_sh <= {r_sh[WORD_W-2*PIX_W-1:0], i_pix};
            if (i_clr)
                r_cnt <= CNT_W'(1);
            else if (r_cnt == LAST_IDX)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CNT_W'(1);
        end else if (i_clr) begin
            r_cnt <= '0;
        end
    end

    // The 10th pixel is appended combinationally so the word reaches the
    // buffer on the same edge that accepts it.
    assign o_word_vld = i_push & ~i_clr & (r_cnt == LAST_IDX);
    assign o_word     = {r_sh, i_pix};

endmodule

// File: rtl/ddr_pix_wr.sv
// ddr_pix_wr: packs a 24-bit pixel stream into 240-bit words and writes them
// as single-beat DDR bursts at consecutive 32-byte addresses, wrapping after
// MAX_ADDR.
// Ports: clk, rstn (async active-low), init_done (DDR calibrated),
// bus (ddr_pix_wr_if.slave: pixel stream in, DDR write channel out).
// Build option: DDR_PIX_WR_PATTERN_EN replaces pix_data with an internal
// 8-bar colour pattern generator.
//
// state   | meaning
// IDLE    | waiting for a buffered word, controller not busy, DDR ready
// REQ     | wr_req high, address held until wdata_ready
// DATA    | word consumed; advance or wrap the address
module ddr_pix_wr
    import ddr_pix_wr_pkg::*;
#(
    parameter logic [ADDR_W-1:0] MAX_ADDR = 28'hFFF_FFE0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         init_done,
    ddr_pix_wr_if.slave  bus
);

    wr_state_t         r_state, w_state_nxt;
    logic              r_run;
    logic [WORD_W-1:0] r_buf [2];
    logic              r_wp, r_rp;
    logic [1:0]        r_cnt;
    logic [1:0]        r_old;
    logic              r_vs_pend;
    logic [ADDR_W-1:0] r_adr;

    logic              w_full, w_accept, w_push, w_pop, w_adr_clr;
    logic              w_wr_req, w_frame_done;
    logic [PIX_W-1:0]  w_pix;
    logic [WORD_W-1:0] w_word;

    // r_run keeps pix_ready low while reset is asserted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_run <= 1'b0;
        else       r_run <= 1'b1;
    end

    assign w_full        = (r_cnt == 2'd2);
    assign bus.pix_ready = r_run & init_done & ~w_full;
    assign w_accept      = bus.pix_valid & bus.pix_ready;
    assign w_pop         = (r_state == ST_REQ) & bus.wdata_ready;

`ifdef DDR_PIX_WR_PATTERN_EN
    logic [7:0] r_bar_pix;
    logic [2:0] r_bar;

    // Eight bars of 160 pixels; the 3-bit bar index wraps at 1280 columns.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bar_pix <= '0;
            r_bar     <= '0;
        end else if (bus.vs_in) begin
            r_bar     <= '0;
            r_bar_pix <= w_accept ? 8'd1 : 8'd0;
        end else if (w_accept) begin
            if (r_bar_pix == 8'(BAR_PIX - 1)) begin
                r_bar_pix <= '0;
                r_bar     <= r_bar + 3'd1;
            end else begin
                r_bar_pix <= r_bar_pix + 8'd1;
            end
        end
    end

    assign w_pix = bus.vs_in ? bar_color(3'd0) : bar_color(r_bar);
`else
    assign w_pix = bus.pix_data;
`endif

    ddr_pix_wr_packer u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .i_clr      (bus.vs_in),
        .i_push     (w_accept),
        .i_pix      (w_pix),
        .o_word_vld (w_push),
        .o_word     (w_word)
    );

    // Two-entry word FIFO; a push never meets a full buffer because
    // pix_ready is low then.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_buf[r_wp] <= w_word;
                r_wp        <= ~r_wp;
            end
            if (w_pop)
                r_rp <= ~r_rp;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // r_old counts words buffered before the last vs_in; they sit at the
    // FIFO head and keep the old frame's addresses. The address restarts
    // at 0 once they are gone and the FSM is idle.
    assign w_adr_clr = (r_state == ST_IDLE) & r_vs_pend & (r_old == 2'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vs_pend <= 1'b0;
            r_old     <= '0;
        end else if (bus.vs_in) begin
            r_vs_pend <= 1'b1;
            r_old     <= r_cnt - {1'b0, w_pop};
        end else begin
            if (w_pop && r_old != 2'd0)
                r_old <= r_old - 2'd1;
            if (w_adr_clr)
                r_vs_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_adr <= '0;
        else if (w_adr_clr)
            r_adr <= '0;
        else if (r_state == ST_DATA)
            r_adr <= (r_adr == MAX_ADDR) ? '0 : r_adr + ADDR_W'(ADDR_STEP);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (r_cnt != 2'd0 && !bus.ddr_wbusy && init_done)
                         w_state_nxt = ST_REQ;
            ST_REQ:  if (bus.wdata_ready)
                         w_state_nxt = ST_DATA;
            ST_DATA: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_wr_req     = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_REQ:  w_wr_req     = 1'b1;
            ST_DATA: w_frame_done = (r_adr == MAX_ADDR);
            default: ;
        endcase
    end

    assign bus.wr_req     = w_wr_req;
    assign bus.frame_done = w_frame_done;
    assign bus.ddr_wr_adr = r_adr;
    assign bus.awlen      = 4'd0;
    assign bus.ddr_wdata  = {{(DATA_W-WORD_W){1'b0}}, r_buf[r_rp]};

endmodule

// File: tb/tb_ddr_pix_wr.sv
module tb_ddr_pix_wr;
    import ddr_pix_wr_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    logic init_done;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [ADDR_W-1:0] q_adr [$];
    logic [DATA_W-1:0] q_dat [$];
    int                q_cyc [$];
    int                q_fd  [$];

    ddr_pix_wr_if bus ();

    ddr_pix_wr #(.MAX_ADDR(28'd96)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .init_done (init_done),
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn === 1'b1 && bus.wr_req === 1'b1 && bus.wdata_ready === 1'b1) begin
            q_adr.push_back(bus.ddr_wr_adr);
            q_dat.push_back(bus.ddr_wdata);
            q_cyc.push_back(cyc);
        end
        if (rstn === 1'b1 && bus.frame_done === 1'b1)
            q_fd.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clrq();
        q_adr.delete();
        q_dat.delete();
        q_cyc.delete();
        q_fd.delete();
    endtask

    function automatic logic [255:0] qa(input int i);
        if (i < q_adr.size()) return 256'(q_adr[i]);
        return 'x;
    endfunction

    function automatic logic [255:0] qd(input int i);
        if (i < q_dat.size()) return q_dat[i];
        return 'x;
    endfunction

    function automatic int qc(input int i);
        if (i < q_cyc.size()) return q_cyc[i];
        return -1;
    endfunction

    // Ten consecutive pixels base..base+9, pixel 0 in bits [239:216].
    function automatic logic [255:0] mkword(input logic [23:0] base);
        logic [255:0] w = '0;
        for (int k = 0; k < 10; k++)
            w = (w << 24) | 256'(base + 24'(k));
        return w;
    endfunction

    function automatic logic [255:0] fillword(input logic [23:0] px);
        logic [255:0] w = '0;
        for (int k = 0; k < 10; k++)
            w = (w << 24) | 256'(px);
        return w;
    endfunction

    task automatic send_pix(input logic [23:0] d, output int stamp);
        int k = 0;
        bus.pix_data  = d;
        bus.pix_valid = 1'b1;
        while (bus.pix_ready !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        chk("pix_ready_wait", 256'(k < 200), 256'(1));
        tick();
        stamp = cyc;
        bus.pix_valid = 1'b0;
    endtask

    task automatic send_n(input logic [23:0] base, input int n);
        int s;
        for (int i = 0; i < n; i++)
            send_pix(base + 24'(i), s);
    endtask

    task automatic vs_pulse();
        bus.vs_in = 1'b1;
        tick();
        bus.vs_in = 1'b0;
    endtask

    initial begin
        int st;
        int k;
        rstn            = 1'b0;
        init_done       = 1'b1;
        bus.vs_in       = 1'b0;
        bus.pix_valid   = 1'b0;
        bus.pix_data    = '0;
        bus.wdata_ready = 1'b0;
        bus.ddr_wbusy   = 1'b0;
        tick(); tick(); tick();

        chk("rst_pix_ready",  256'(bus.pix_ready),  256'(0));
        chk("rst_wr_req",     256'(bus.wr_req),     256'(0));
        chk("rst_adr",        256'(bus.ddr_wr_adr), 256'(0));
        chk("rst_awlen",      256'(bus.awlen),      256'(0));
        chk("rst_wdata",      bus.ddr_wdata,        256'(0));
        chk("rst_frame_done", 256'(bus.frame_done), 256'(0));

        rstn            = 1'b1;
        bus.wdata_ready = 1'b1;
        tick();

`ifndef DDR_PIX_WR_PATTERN_EN
        // 1: one word of pixels 1..10
        clrq();
        for (int i = 1; i <= 10; i++)
            send_pix(24'(i), st);
        repeat (10) tick();
        chk("t1_nwr",      256'(q_adr.size()), 256'(1));
        chk("t1_adr",      qa(0), 256'(0));
        chk("t1_pix0",     256'(qd(0)[239:216]), 256'(24'h000001));
        chk("t1_pix9",     256'(qd(0)[23:0]),    256'(24'h00000A));
        chk("t1_pad",      256'(qd(0)[255:240]), 256'(0));
        chk("t1_word",     qd(0), mkword(24'h000001));
        chk("t1_latency",  256'(qc(0)), 256'(st + 1));
        chk("t1_awlen",    256'(bus.awlen), 256'(0));
        chk("t1_adr_next", 256'(bus.ddr_wr_adr), 256'(32));

        // 2: back-pressure with two buffered words, then drain in order
        vs_pulse();
        tick();
        chk("t2_adr_vs", 256'(bus.ddr_wr_adr), 256'(0));
        clrq();
        bus.wdata_ready = 1'b0;
        send_n(24'h000100, 20);
        bus.pix_data  = 24'h000114;
        bus.pix_valid = 1'b1;
        repeat (20) tick();
        chk("t2_ready_low", 256'(bus.pix_ready), 256'(0));
        chk("t2_req_held",  256'(bus.wr_req),    256'(1));
        chk("t2_adr_held",  256'(bus.ddr_wr_adr), 256'(0));
        chk("t2_no_wr",     256'(q_adr.size()),  256'(0));
        bus.wdata_ready = 1'b1;
        send_n(24'h000114, 10);
        repeat (20) tick();
        chk("t2_nwr",  256'(q_adr.size()), 256'(3));
        chk("t2_adr0", qa(0), 256'(0));
        chk("t2_adr1", qa(1), 256'(32));
        chk("t2_adr2", qa(2), 256'(64));
        chk("t2_dat0", qd(0), mkword(24'h000100));
        chk("t2_dat1", qd(1), mkword(24'h00010A));
        chk("t2_dat2", qd(2), mkword(24'h000114));
        chk("t2_no_fd", 256'(q_fd.size()), 256'(0));

        // 3: wrap at MAX_ADDR (96) with a single frame_done pulse
        clrq();
        send_n(24'h000200, 20);
        repeat (20) tick();
        chk("t3_nwr",  256'(q_adr.size()), 256'(2));
        chk("t3_adr0", qa(0), 256'(96));
        chk("t3_adr1", qa(1), 256'(0));
        chk("t3_dat1", qd(1), mkword(24'h00020A));
        chk("t3_nfd",  256'(q_fd.size()), 256'(1));
        chk("t3_fd_cycle", 256'(q_fd.size() > 0 ? q_fd[0] : -1), 256'(qc(0) + 1));
        chk("t3_adr_next", 256'(bus.ddr_wr_adr), 256'(32));

        // 4: partial word dropped by vs_in; vs pixel becomes pixel 0
        clrq();
        send_n(24'h000300, 7);
        repeat (5) tick();
        chk("t4_no_partial", 256'(q_adr.size()), 256'(0));
        bus.vs_in = 1'b1;
        send_pix(24'h000310, st);
        bus.vs_in = 1'b0;
        send_n(24'h000311, 9);
        repeat (20) tick();
        chk("t4_nwr", 256'(q_adr.size()), 256'(1));
        chk("t4_adr", qa(0), 256'(0));
        chk("t4_dat", qd(0), mkword(24'h000310));

        // 5: asynchronous reset while a request is pending
        clrq();
        bus.wdata_ready = 1'b0;
        send_n(24'h000400, 10);
        k = 0;
        while (bus.wr_req !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        chk("t5_req_seen", 256'(bus.wr_req), 256'(1));
        #2 rstn = 1'b0;
        #1;
        chk("t5_async_req",   256'(bus.wr_req),    256'(0));
        chk("t5_async_wdata", bus.ddr_wdata,       256'(0));
        chk("t5_async_ready", 256'(bus.pix_ready), 256'(0));
        tick(); tick();
        init_done = 1'b0;
        rstn = 1'b1;
        bus.wdata_ready = 1'b1;
        repeat (3) tick();
        chk("t5_init_low_ready", 256'(bus.pix_ready), 256'(0));
        init_done = 1'b1;
        repeat (20) tick();
        chk("t5_no_wr", 256'(q_adr.size()), 256'(0));
        send_n(24'h000500, 10);
        repeat (20) tick();
        chk("t5_nwr", 256'(q_adr.size()), 256'(1));
        chk("t5_adr", qa(0), 256'(0));
        chk("t5_dat", qd(0), mkword(24'h000500));
`else
        // Pattern build: first bar white for 160 pixels, then yellow.
        clrq();
        send_n(24'h000000, 170);
        repeat (20) tick();
        chk("pat_nwr", 256'(q_dat.size()), 256'(17));
        for (int i = 0; i < 16; i++)
            chk($sformatf("pat_white_w%0d", i), qd(i), fillword(24'hFFFFFF));
        chk("pat_yellow_w16", qd(16), fillword(24'hFFFF00));
        chk("pat_pix160", 256'(qd(16)[239:216]), 256'(24'hFFFF00));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
